// File: rtl/bool_seq_pkg.sv
// Shared types and helpers for the boolean-function vector sequencer.
// Holds the sweep FSM state encoding and the truth-table width calculation.
package bool_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Number of truth-table rows (and captured/expected bits) for n inputs.
  function automatic int tbl_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/bool_resp_checker.sv
// Response side of the sequencer: records y per row into a truth table and
// counts rows that disagree with the expected table.
module bool_resp_checker
  import bool_seq_pkg::*;
#(
  parameter int                              N_IN   = 3,
  parameter logic [tbl_width(N_IN)-1:0]      EXPECT = 8'hEA
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       strobe,
  input  logic [N_IN-1:0]            idx,
  input  logic                       y,
  output logic [N_IN:0]              err_cnt,
  output logic [tbl_width(N_IN)-1:0] captured,
  output logic                       row_err
);

  localparam int CW = N_IN + 1;

  logic [CW-1:0]              r_err_cnt;
  logic [tbl_width(N_IN)-1:0] r_captured;

  // Combinational so the sequencer can fold the final row into pass.
  assign row_err = strobe && (y != EXPECT[idx]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt  <= '0;
      r_captured <= '0;
    end else if (clear) begin
      r_err_cnt  <= '0;
      r_captured <= '0;
    end else if (strobe) begin
      r_captured[idx] <= y;
      if (row_err) r_err_cnt <= r_err_cnt + CW'(1);
    end
  end

  assign err_cnt  = r_err_cnt;
  assign captured = r_captured;

endmodule

// File: rtl/bool_vector_sequencer.sv
// Exhaustive truth-table sweeper: drives vec in counting order, holds each
// row DWELL cycles, samples y on the last cycle and reports pass/fail.
module bool_vector_sequencer
  import bool_seq_pkg::*;
#(
  parameter int                         N_IN   = 3,
  parameter int                         DWELL  = 4,
  parameter logic [tbl_width(N_IN)-1:0] EXPECT = 8'hEA
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  output logic [N_IN-1:0]            vec,
  input  logic                       y,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [N_IN:0]              err_cnt,
  output logic [tbl_width(N_IN)-1:0] captured
);

  localparam int             DW         = $clog2(DWELL);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = {N_IN{1'b1}};

  seq_state_t      r_state, w_state_nxt;
  logic [N_IN-1:0] r_vec, w_vec_nxt;
  logic [DW-1:0]   r_dwell, w_dwell_nxt;
  logic            r_pass, w_pass_nxt;
  logic            w_clear, w_strobe, w_row_err;
  logic [N_IN:0]   w_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_vec   <= '0;
      r_dwell <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_dwell <= w_dwell_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  // NOTE: every output of this block is defaulted first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_dwell_nxt = r_dwell;
    w_pass_nxt  = r_pass;
    w_clear     = 1'b0;
    w_strobe    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!abort && start) begin
          w_clear     = 1'b1;
          w_pass_nxt  = 1'b0;
          w_vec_nxt   = '0;
          w_dwell_nxt = '0;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_vec_nxt   = '0;
          w_dwell_nxt = '0;
          w_pass_nxt  = 1'b0;
        end else if (r_dwell == DWELL_LAST) begin
          w_strobe    = 1'b1;
          w_dwell_nxt = '0;
          if (r_vec == VEC_LAST) begin
            // Last row: its own mismatch is not yet in err_cnt.
            w_state_nxt = DONE;
            w_pass_nxt  = (w_err_cnt == '0) && !w_row_err;
          end else begin
            w_vec_nxt = r_vec + N_IN'(1);
          end
        end else begin
          w_dwell_nxt = r_dwell + DW'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_vec_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_vec_nxt   = '0;
        w_dwell_nxt = '0;
      end
    endcase
  end

  bool_resp_checker #(
    .N_IN   (N_IN),
    .EXPECT (EXPECT)
  ) u_checker (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_clear),
    .strobe   (w_strobe),
    .idx      (r_vec),
    .y        (y),
    .err_cnt  (w_err_cnt),
    .captured (captured),
    .row_err  (w_row_err)
  );

  assign vec     = r_vec;
  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign pass    = r_pass;
  assign err_cnt = w_err_cnt;

endmodule

// File: tb/tb_bool_vector_sequencer.sv
// Directed bench for bool_vector_sequencer at default parameters, with a
// selectable behavioural model of the function under test on y.
module tb_bool_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] vec;
  logic       y;
  logic       busy, done, pass;
  logic [3:0] err_cnt;
  logic [7:0] captured;

  int n_checks = 0;
  int n_fail   = 0;
  int y_mode   = 0;  // 0: (a&b)|c, 1: tied 0, 2: ~((a&b)|c)

  always #5 clk = ~clk;

  always_comb begin
    y = 1'b0;
    case (y_mode)
      0: y = (vec[2] & vec[1]) | vec[0];
      1: y = 1'b0;
      2: y = ~((vec[2] & vec[1]) | vec[0]);
      default: y = 1'b0;
    endcase
  end

  bool_vector_sequencer #(
    .N_IN   (3),
    .DWELL  (4),
    .EXPECT (8'hEA)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .vec      (vec),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .captured (captured)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch a sweep: start is seen at the next edge (E0).
  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({vec, busy, done, pass, err_cnt, captured} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_state: vec=%0d busy=%b done=%b pass=%b err_cnt=%0d captured=%h, all required 0",
               vec, busy, done, pass, err_cnt, captured);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0 || vec !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy=%b vec=%0d, required busy=0 vec=0", busy, vec);
    end
  endtask

  task automatic test_sweep(input string name, input int mode, input logic [3:0] exp_err,
                            input logic [7:0] exp_cap, input logic exp_pass);
    y_mode = mode;
    launch();
    n_checks++;
    if (busy !== 1'b1 || vec !== 3'd0 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_launch: busy=%b vec=%0d pass=%b, required busy=1 vec=0 pass=0",
               name, busy, vec, pass);
    end
    for (int e = 1; e <= 33; e++) begin
      step();
      n_checks++;
      if (e < 32) begin
        if (vec !== 3'(e / 4) || busy !== 1'b1 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_row_E%0d: vec=%0d busy=%b done=%b, required vec=%0d busy=1 done=0",
                   name, e, vec, busy, done, e / 4);
        end
      end else if (e == 32) begin
        if (done !== 1'b1 || busy !== 1'b0 || vec !== 3'd7 || pass !== exp_pass ||
            err_cnt !== exp_err || captured !== exp_cap) begin
          n_fail++;
          $display("FAIL %s_end_E32: done=%b busy=%b vec=%0d pass=%b err_cnt=%0d captured=%h, required done=1 busy=0 vec=7 pass=%b err_cnt=%0d captured=%h",
                   name, done, busy, vec, pass, err_cnt, captured, exp_pass, exp_err, exp_cap);
        end
      end else begin
        if (done !== 1'b0 || busy !== 1'b0 || vec !== 3'd0 || pass !== exp_pass ||
            err_cnt !== exp_err || captured !== exp_cap) begin
          n_fail++;
          $display("FAIL %s_hold_E33: done=%b busy=%b vec=%0d pass=%b err_cnt=%0d captured=%h, required done=0 busy=0 vec=0 pass=%b err_cnt=%0d captured=%h",
                   name, done, busy, vec, pass, err_cnt, captured, exp_pass, exp_err, exp_cap);
        end
      end
    end
  endtask

  // Preceded by a sweep that left captured=8'hEA, so bit 3 must be cleared.
  task automatic test_abort();
    y_mode = 0;
    launch();
    for (int e = 1; e <= 13; e++) step();
    abort = 1'b1;
    step();  // E14
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || vec !== 3'd0 || done !== 1'b0 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ctrl: busy=%b vec=%0d done=%b pass=%b, required busy=0 vec=0 done=0 pass=0",
               busy, vec, done, pass);
    end
    n_checks++;
    if (err_cnt !== 4'd0 || captured[3:0] !== 4'b0010) begin
      n_fail++;
      $display("FAIL abort_partial: err_cnt=%0d captured[3:0]=%b, required err_cnt=0 captured[3:0]=0010",
               err_cnt, captured[3:0]);
    end
    for (int e = 0; e < 25; e++) begin
      step();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done_%0d: done=%b busy=%b, required done=0 busy=0", e, done, busy);
      end
    end
  endtask

  task automatic test_start_in_run();
    y_mode = 0;
    launch();
    for (int e = 1; e <= 33; e++) begin
      step();
      if (e == 9) start = 1'b1;
      if (e == 10) start = 1'b0;
      n_checks++;
      if (done !== (e == 32) || vec !== ((e < 32) ? 3'(e / 4) : (e == 32) ? 3'd7 : 3'd0)) begin
        n_fail++;
        $display("FAIL restart_ignored_E%0d: done=%b vec=%0d, required done=%b", e, done, vec, e == 32);
      end
    end
    n_checks++;
    if (pass !== 1'b1 || err_cnt !== 4'd0 || captured !== 8'hEA) begin
      n_fail++;
      $display("FAIL restart_result: pass=%b err_cnt=%0d captured=%h, required pass=1 err_cnt=0 captured=ea",
               pass, err_cnt, captured);
    end
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    for (int e = 0; e < 3; e++) begin
      step();
      n_checks++;
      if (busy !== 1'b0 || vec !== 3'd0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL start_abort_idle_%0d: busy=%b vec=%0d done=%b, required busy=0 vec=0 done=0",
                 e, busy, vec, done);
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  // start held high across a completed sweep relaunches at E34.
  task automatic test_back_to_back();
    y_mode = 0;
    @(negedge clk);
    start = 1'b1;
    step();  // E0
    for (int e = 1; e <= 34; e++) begin
      step();
      if (e == 32) begin
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_done_E32: done=%b pass=%b, required done=1 pass=1", done, pass);
        end
      end else if (e == 33) begin
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_idle_E33: busy=%b done=%b, required busy=0 done=0", busy, done);
        end
      end else if (e == 34) begin
        n_checks++;
        if (busy !== 1'b1 || vec !== 3'd0 || pass !== 1'b0 || captured !== 8'h00) begin
          n_fail++;
          $display("FAIL b2b_relaunch_E34: busy=%b vec=%0d pass=%b captured=%h, required busy=1 vec=0 pass=0 captured=00",
                   busy, vec, pass, captured);
        end
      end
    end
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_abort: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    y_mode = 2;
    launch();
    for (int e = 1; e <= 18; e++) step();
    n_checks++;
    if (err_cnt !== 4'd4 || captured !== 8'h05 || vec !== 3'd4) begin
      n_fail++;
      $display("FAIL reset_mid_pre: err_cnt=%0d captured=%h vec=%0d, required err_cnt=4 captured=05 vec=4",
               err_cnt, captured, vec);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({vec, busy, done, pass, err_cnt, captured} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: vec=%0d busy=%b done=%b pass=%b err_cnt=%0d captured=%h, all required 0",
               vec, busy, done, pass, err_cnt, captured);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 20; e++) begin
      step();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_no_done_%0d: busy=%b done=%b, required 0", e, busy, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep("match",  0, 4'd0, 8'hEA, 1'b1);
    test_abort();
    test_sweep("tied0",  1, 4'd5, 8'h00, 1'b0);
    test_sweep("invert", 2, 4'd8, 8'h15, 1'b0);
    test_start_in_run();
    test_start_abort_idle();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
